// File: rtl/ped_pkg.sv
// Shared types and defaults for the pedestrian-request front end.
// Imported by btn_debounce and ped_request.
package ped_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_COOL = 1'b1
    } ped_state_e;

    localparam int PED_DEBOUNCE_DEF = 16;
    localparam int PED_COOLDOWN_DEF = 1024;

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser, debouncer and press-edge detector.
// rise is a one-cycle pulse on each accepted press.
module btn_debounce
    import ped_pkg::*;
#(
    parameter int DEBOUNCE = PED_DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    // A single-cycle debounce still needs a 1-bit counter.
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic          s1_q;
    logic          s2_q;
    logic          db_q;
    logic          db_d;
    logic          db_dly_q;
    logic [DW-1:0] dcnt_q;
    logic [DW-1:0] dcnt_d;

    // Accept a new level only after it has been stable long enough
    always_comb begin
        db_d   = db_q;
        dcnt_d = '0;
        if (s2_q != db_q) begin
            if (dcnt_q == DW'(DEBOUNCE - 1)) begin
                db_d = s2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, debounce state and delayed level for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
            dcnt_q   <= '0;
        end else begin
            s1_q     <= btn;
            s2_q     <= s1_q;
            db_q     <= db_d;
            db_dly_q <= db_q;
            dcnt_q   <= dcnt_d;
        end
    end

    assign rise = db_q & ~db_dly_q;

endmodule

// File: rtl/ped_request.sv
// Pedestrian-request front end: qualifies debounced presses against
// green and spaces pass pulses by at least one cooldown window.
module ped_request
    import ped_pkg::*;
#(
    parameter int DEBOUNCE = PED_DEBOUNCE_DEF,
    parameter int COOLDOWN = PED_COOLDOWN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic green,
    output logic pass,
    output logic pending,
    output logic busy,
    output logic ignored
);

    localparam int CW = $clog2(COOLDOWN);

    logic          rise;
    logic          expire;
    logic          req;
    ped_state_e    state_q;
    ped_state_e    state_d;
    logic [CW-1:0] ccnt_q;
    logic [CW-1:0] ccnt_d;
    logic          pass_q;
    logic          pass_d;
    logic          ign_q;
    logic          ign_d;
    logic          pend_q;
    logic          pend_d;

    btn_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .clk (clk),
        .rst (rst),
        .btn (btn),
        .rise(rise)
    );

    assign expire = (ccnt_q == CW'(COOLDOWN - 1));
    assign req    = pend_q | rise;

    // Request FSM; green only matters where a request is issued or dropped
    always_comb begin
        state_d = state_q;
        ccnt_d  = ccnt_q;
        pass_d  = 1'b0;
        ign_d   = 1'b0;
        pend_d  = pend_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    if (!green) begin
                        pass_d  = 1'b1;
                        ccnt_d  = '0;
                        state_d = ST_COOL;
                    end else begin
                        ign_d = 1'b1;
                    end
                end
            end
            ST_COOL: begin
                ccnt_d = ccnt_q + 1'b1;
                if (expire) begin
                    pend_d = 1'b0;
                    if (req && !green) begin
                        pass_d = 1'b1;
                        ccnt_d = '0;
                    end else begin
                        ign_d   = req;
                        ccnt_d  = '0;
                        state_d = ST_IDLE;
                    end
                end else if (rise) begin
                    pend_d = 1'b1;
                end
            end
        endcase
    end

    // State, cooldown counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ccnt_q  <= '0;
            pass_q  <= 1'b0;
            ign_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ccnt_q  <= ccnt_d;
            pass_q  <= pass_d;
            ign_q   <= ign_d;
            pend_q  <= pend_d;
        end
    end

    assign pass    = pass_q;
    assign ignored = ign_q;
    assign pending = pend_q;
    assign busy    = (state_q == ST_COOL);

endmodule

// File: tb/tb_ped_request.sv
// Bench for ped_request: timestamp-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ped_request;

    localparam int D = 4;
    localparam int C = 32;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic green;
    logic pass;
    logic pending;
    logic busy;
    logic ignored;

    int checks   = 0;
    int failures = 0;

    ped_request #(
        .DEBOUNCE(D),
        .COOLDOWN(C)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .green  (green),
        .pass   (pass),
        .pending(pending),
        .busy   (busy),
        .ignored(ignored)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: sampled button history and pass timestamps
    bit m_s1, m_s2, m_db, m_dbq;
    bit hist [64];
    int cyc = 0;
    int lastflip = 0;
    bit cool, pend, e_pass, e_ign;
    int t0 = 0;
    bit chk_en = 0;

    always @(posedge clk) begin
        bit rise, req, flip;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_dbq = 0;
            cool = 0; pend = 0; e_pass = 0; e_ign = 0;
            lastflip = cyc;
            chk_en = 1;
        end else begin
            rise = m_db && !m_dbq;
            e_pass = 0;
            e_ign = 0;
            if (!cool) begin
                if (rise) begin
                    if (!green) begin
                        e_pass = 1; cool = 1; t0 = cyc;
                    end else begin
                        e_ign = 1;
                    end
                end
            end else if (cyc - t0 == C) begin
                req = pend || rise;
                pend = 0;
                if (req && !green) begin
                    e_pass = 1; t0 = cyc;
                end else begin
                    e_ign = req; cool = 0;
                end
            end else if (rise) begin
                pend = 1;
            end
            hist[cyc % 64] = m_s2;
            flip = 1;
            for (int j = 0; j < D; j++) begin
                if (cyc - j <= lastflip || hist[(cyc - j) % 64] == m_db)
                    flip = 0;
            end
            m_dbq = m_db;
            if (flip) begin
                m_db = !m_db;
                lastflip = cyc;
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_pass", pass, e_pass);
            chk("model_ignored", ignored, e_ign);
            chk("model_pending", pending, pend);
            chk("model_busy", busy, cool);
        end
    end

    initial begin
        int hold;
        rst = 1; btn = 0; green = 0;
        step(3);
        chk("rst_pass", pass, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ignored", ignored, 0);
        rst = 0;
        step(5);

        // clean press
        btn = 1;
        step(6);
        chk("clean_pass_early", pass, 0);
        step(1);
        chk("clean_pass", pass, 1);
        chk("clean_busy", busy, 1);
        chk("clean_pending", pending, 0);
        step(1);
        chk("clean_pass_1cyc", pass, 0);
        step(12);
        btn = 0;
        step(18);
        chk("clean_busy_end", busy, 1);
        step(1);
        chk("clean_busy_off", busy, 0);
        step(10);

        // bounce
        btn = 1; step(1); btn = 0; step(1);
        btn = 1; step(1); btn = 0;
        step(12);
        chk("bounce_busy", busy, 0);

        // green gating
        green = 1; btn = 1;
        step(7);
        chk("green_ign", ignored, 1);
        chk("green_pass", pass, 0);
        chk("green_busy", busy, 0);
        step(1);
        chk("green_ign_1cyc", ignored, 0);
        btn = 0; green = 0;
        step(20);

        // queued press
        btn = 1;
        step(7);
        chk("q_pass1", pass, 1);
        step(2);
        btn = 0;
        step(7);
        btn = 1;
        step(7);
        chk("q_pending", pending, 1);
        chk("q_busy", busy, 1);
        step(15);
        chk("q_pending_hold", pending, 1);
        chk("q_pass_early", pass, 0);
        step(1);
        chk("q_pass2", pass, 1);
        chk("q_pending_clr", pending, 0);
        chk("q_busy2", busy, 1);
        btn = 0;
        step(31);
        chk("q_busy_end", busy, 1);
        step(1);
        chk("q_busy_off", busy, 0);
        step(10);

        // expiry collision with green high
        btn = 1;
        step(7);
        chk("col_pass1", pass, 1);
        step(2);
        btn = 0;
        step(23);
        btn = 1; green = 1;
        step(6);
        chk("col_ign_early", ignored, 0);
        chk("col_busy_pre", busy, 1);
        step(1);
        chk("col_ign", ignored, 1);
        chk("col_pass", pass, 0);
        chk("col_busy", busy, 0);
        chk("col_pending", pending, 0);
        btn = 0; green = 0;
        step(20);

        // reset mid-cooldown with a queued request
        btn = 1;
        step(7);
        chk("rm_pass1", pass, 1);
        step(2);
        btn = 0;
        step(10);
        btn = 1;
        step(8);
        chk("rm_pending", pending, 1);
        chk("rm_busy", busy, 1);
        rst = 1;
        step(1);
        chk("rm_rst_pass", pass, 0);
        chk("rm_rst_pending", pending, 0);
        chk("rm_rst_busy", busy, 0);
        chk("rm_rst_ign", ignored, 0);
        rst = 0;
        step(6);
        chk("rm_pass_early", pass, 0);
        step(1);
        chk("rm_pass", pass, 1);
        btn = 0;
        step(40);

        // randomized traffic
        hold = 0;
        for (int i = 0; i < 5000; i++) begin
            if (hold == 0) begin
                btn = 1'($urandom % 2);
                hold = $urandom_range(1, 12);
            end
            hold--;
            if ($urandom % 8 == 0) green = ~green;
            rst = ($urandom % 400 == 0);
            step(1);
        end
        rst = 0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ped_request.md
# ped_request

Pedestrian-request front end for the traffic-light controller. Synchronises and debounces a raw crossing push-button and qualifies each press against the light's current green output. Issues single-cycle `pass` pulses to the controller, no more often than once per cooldown window. Sits directly upstream of the controller: `pass` drives the controller's `pass` input, and `green` is the controller's `G` output fed back.

## Interface

Parameters:
- `DEBOUNCE`, 16: consecutive stable cycles needed to accept a button level change; legal range ≥1.
- `COOLDOWN`, 1024: minimum cycles from one `pass` pulse to the next; legal range ≥2.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `btn`  in  1  raw asynchronous push-button, active-high.
- `green`  in  1  controller `G` output.
- `pass`  out  1  one-cycle request pulse to the controller.
- `pending`  out  1  a request is queued behind the cooldown.
- `busy`  out  1  cooldown window active.
- `ignored`  out  1  one-cycle pulse when a request is discarded because `green` is high.

## Operation

- **Synchroniser:** two flops, `btn` → `s1` → `s2`.
- **Debouncer:** holds level `db` and counter `dcnt`.
  - `s2 == db`: `dcnt` is cleared to 0.
  - `s2 != db` and `dcnt == DEBOUNCE-1`: `db` takes `s2` and `dcnt` is cleared.
  - `s2 != db` otherwise: `dcnt` increments.
- **Press event:** `rise = db & ~db_q`, where `db_q` is `db` delayed one cycle. Only the press edge matters; release is ignored.
- **FSM states:** IDLE and COOL.
- **IDLE:**
  - `rise` with `green == 0`: `pass` is registered high, `ccnt` is cleared, and the FSM moves to COOL.
  - `rise` with `green == 1`: `ignored` is registered high and the FSM stays in IDLE.
- **COOL:** `ccnt` increments every cycle and `busy` is 1.
  - A `rise` in COOL sets `pending`. The queue is one deep, so further rises merge into it.
- **COOL expiry** happens when `ccnt == COOLDOWN-1`:
  - `pending` set and `green == 0`: `pass` pulses, `ccnt` is cleared, the FSM stays in COOL, and `pending` clears.
  - `pending` set and `green == 1`: `ignored` pulses, the FSM goes to IDLE, and `pending` clears.
  - `pending` clear: the FSM goes to IDLE.
- **Simultaneous `rise` and expiry:** treated as `pending` OR `rise`, then the expiry rules apply.
- **`green` sampling:** `green` is sampled only at the edge that issues or drops a request. Toggling `green` at any other time, including the controller's flashing-green phases, has no effect.
- **Counter width:** `ccnt` is `$clog2(COOLDOWN)` bits and never wraps, because it is cleared at expiry.

## Timing

- **Reset values:** `pass`, `pending`, `busy`, `ignored` = 0; `s1`, `s2`, `db`, `db_q` = 0; counters = 0; state = IDLE.
- **Reset mid-operation:** a `rst` asserted at any cycle aborts cooldown and drops any `pending` request. A button held through reset is treated as a new press once `rst` deasserts.
- **Press latency:** `btn` is first sampled high at edge k and held. Then `pass` (or `ignored`) is high for exactly the one cycle after edge k+`DEBOUNCE`+2.
- **Glitch rejection:** a `btn` pulse shorter than `DEBOUNCE` cycles after synchronisation produces no event.
- **Pass spacing:** the rising edges of consecutive `pass` pulses are at least `COOLDOWN` cycles apart.
- **Output pulses:** `pass` and `ignored` are never high together, and each lasts exactly 1 cycle.

## Structure

- **Shared package `ped_pkg`:**
  - state enum (`ST_IDLE`, `ST_COOL`);
  - default constants `PED_DEBOUNCE_DEF` = 16 and `PED_COOLDOWN_DEF` = 1024.
- **Sub-module `btn_debounce`:** contains the synchroniser, debouncer and rise detection.
  - Ports: `clk`, `rst`, `btn`, `rise`.
  - Parameter: `DEBOUNCE`.
- **Top `ped_request`:** instantiates `btn_debounce` and holds the FSM, cooldown counter and output registers.

## Test plan

All scenarios use `DEBOUNCE` = 4 and `COOLDOWN` = 32.

- **Clean press:** `btn` rises at edge 10 and is held for 20 cycles, `green` = 0 → `pass` is high only in the cycle after edge 16; `busy` is high for the next 32 cycles; `pending` = 0.
- **Bounce:** `btn` toggles 1,0,1,0 on four consecutive cycles and then stays 0 → `pass` and `ignored` never assert.
- **Green gating:** press with `green` = 1 → `ignored` is high for 1 cycle, `pass` stays 0, `busy` stays 0.
- **Queued press:** press, then a second press 10 cycles into cooldown with `green` = 0 → `pending` = 1 until expiry; the second `pass` comes exactly 32 cycles after the first; `busy` stays high for another 32 cycles.
- **Expiry collision:** the second press's `rise` coincides with the expiry edge, then `green` = 1 at expiry → `ignored` pulses; the FSM returns to IDLE; `pending` = 0.
- **Reset mid-cooldown:** `rst` is asserted while `pending` = 1 and `busy` = 1 → all outputs are 0 on the next cycle; `btn` still held after reset gives `pass` `DEBOUNCE`+3 edges after `rst` deasserts.
